// File: rtl/subtractor_with_tree_borrow_32_pipe.sv
// Two-stage pipelined subtractor: diff = a - b - borrow_in with borrow/zero/overflow flags.
// Each stage resolves half the word with a Kogge-Stone borrow tree; valid/ready on both sides.

module subtractor_with_tree_borrow_32_pipe_prefix #(
    parameter int unsigned W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         borrow_in,
    output logic [W-1:0] diff,
    output logic         borrow_out
);
    localparam int unsigned LEVELS = $clog2(W + 1);

    // Position 0 of the extended vectors carries borrow_in as a generate with no propagate.
    for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
        logic [W:0] g;
        logic [W:0] p;
        if (l == 0) begin : g_base
            assign g = {~a & b, borrow_in};
            assign p = {~(a ^ b), 1'b0};
        end else begin : g_step
            localparam int unsigned D = 1 << (l - 1);
            assign g = g_lvl[l-1].g | (g_lvl[l-1].p & (g_lvl[l-1].g << D));
            assign p = g_lvl[l-1].p & (g_lvl[l-1].p << D);
        end
    end

    // Group generate at index i is the borrow into bit i.
    assign diff       = a ^ b ^ g_lvl[LEVELS].g[W-1:0];
    assign borrow_out = g_lvl[LEVELS].g[W];

    logic unused_p;
    assign unused_p = ^g_lvl[LEVELS].p;
endmodule

module subtractor_with_tree_borrow_32_pipe #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned LO_WIDTH = WIDTH / 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             zero,
    output logic             overflow
);
    localparam int unsigned HI_WIDTH = WIDTH - LO_WIDTH;

    logic                s1_valid_q,  s1_valid_d;
    logic [LO_WIDTH-1:0] s1_lo_diff_q, s1_lo_diff_d;
    logic                s1_bm_q,     s1_bm_d;
    logic [HI_WIDTH-1:0] s1_a_hi_q,   s1_a_hi_d;
    logic [HI_WIDTH-1:0] s1_b_hi_q,   s1_b_hi_d;

    logic                out_valid_q,  out_valid_d;
    logic [WIDTH-1:0]    diff_q,       diff_d;
    logic                borrow_out_q, borrow_out_d;
    logic                zero_q,       zero_d;
    logic                overflow_q,   overflow_d;

    logic                s1_en_c;
    logic                s2_en_c;
    logic [LO_WIDTH-1:0] lo_diff_c;
    logic                lo_bout_c;
    logic [HI_WIDTH-1:0] hi_diff_c;
    logic                hi_bout_c;
    logic [WIDTH-1:0]    full_diff_c;

    // Stage 2 advances when the output is empty or being popped; stage 1 when it can hand off.
    assign s2_en_c  = !out_valid_q || out_ready;
    assign s1_en_c  = !s1_valid_q || s2_en_c;
    assign in_ready = s1_en_c;

    subtractor_with_tree_borrow_32_pipe_prefix #(.W(LO_WIDTH)) u_lo (
        .a          (a[LO_WIDTH-1:0]),
        .b          (b[LO_WIDTH-1:0]),
        .borrow_in  (borrow_in),
        .diff       (lo_diff_c),
        .borrow_out (lo_bout_c)
    );

    subtractor_with_tree_borrow_32_pipe_prefix #(.W(HI_WIDTH)) u_hi (
        .a          (s1_a_hi_q),
        .b          (s1_b_hi_q),
        .borrow_in  (s1_bm_q),
        .diff       (hi_diff_c),
        .borrow_out (hi_bout_c)
    );

    assign full_diff_c = {hi_diff_c, s1_lo_diff_q};

    always_comb begin
        s1_valid_d   = s1_valid_q;
        s1_lo_diff_d = s1_lo_diff_q;
        s1_bm_d      = s1_bm_q;
        s1_a_hi_d    = s1_a_hi_q;
        s1_b_hi_d    = s1_b_hi_q;
        out_valid_d  = out_valid_q;
        diff_d       = diff_q;
        borrow_out_d = borrow_out_q;
        zero_d       = zero_q;
        overflow_d   = overflow_q;

        // Operands are captured only on an actual transfer.
        if (s1_en_c) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_lo_diff_d = lo_diff_c;
                s1_bm_d      = lo_bout_c;
                s1_a_hi_d    = a[WIDTH-1:LO_WIDTH];
                s1_b_hi_d    = b[WIDTH-1:LO_WIDTH];
            end
        end

        if (s2_en_c) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                diff_d       = full_diff_c;
                borrow_out_d = hi_bout_c;
                zero_d       = (full_diff_c == '0);
                overflow_d   = (s1_a_hi_q[HI_WIDTH-1] != s1_b_hi_q[HI_WIDTH-1]) &&
                               (full_diff_c[WIDTH-1] != s1_a_hi_q[HI_WIDTH-1]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q   <= 1'b0;
            s1_lo_diff_q <= '0;
            s1_bm_q      <= 1'b0;
            s1_a_hi_q    <= '0;
            s1_b_hi_q    <= '0;
            out_valid_q  <= 1'b0;
            diff_q       <= '0;
            borrow_out_q <= 1'b0;
            zero_q       <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_lo_diff_q <= s1_lo_diff_d;
            s1_bm_q      <= s1_bm_d;
            s1_a_hi_q    <= s1_a_hi_d;
            s1_b_hi_q    <= s1_b_hi_d;
            out_valid_q  <= out_valid_d;
            diff_q       <= diff_d;
            borrow_out_q <= borrow_out_d;
            zero_q       <= zero_d;
            overflow_q   <= overflow_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign diff       = diff_q;
    assign borrow_out = borrow_out_q;
    assign zero       = zero_q;
    assign overflow   = overflow_q;
endmodule

// File: tb/tb_subtractor_with_tree_borrow_32_pipe.sv
// Bench for the pipelined tree-borrow subtractor: directed vector table, stall/reset
// sequences and randomized traffic with random back-pressure against an arithmetic model.

module tb_subtractor_with_tree_borrow_32_pipe;
    localparam int unsigned WIDTH = 32;
    localparam int NV = 12;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             borrow_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;
    logic             zero;
    logic             overflow;

    subtractor_with_tree_borrow_32_pipe dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .borrow_in  (borrow_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .diff       (diff),
        .borrow_out (borrow_out),
        .zero       (zero),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [WIDTH-1:0] diff;
        logic             bout;
        logic             zero;
        logic             ovf;
    } res_t;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             bin;
        res_t             exp;
    } vec_t;

    res_t exp_q[$];
    vec_t tbl[NV];
    int   errors   = 0;
    int   checks   = 0;
    int   accepted = 0;
    int   cyc      = 0;
    bit   rnd_done = 0;

    // Reference: plain wide arithmetic, flags straight from their definitions.
    function automatic res_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                   input logic bin);
        res_t r;
        logic [WIDTH:0] w;
        w      = {1'b0, x} - {1'b0, y} - (WIDTH+1)'(bin);
        r.diff = w[WIDTH-1:0];
        r.bout = w[WIDTH];
        r.zero = (r.diff == '0);
        r.ovf  = (x[WIDTH-1] != y[WIDTH-1]) && (r.diff[WIDTH-1] != x[WIDTH-1]);
        return r;
    endfunction

    function automatic vec_t tv(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                input logic bin, input logic [WIDTH-1:0] d,
                                input logic bo, input logic z, input logic ov);
        vec_t v;
        v.a = x; v.b = y; v.bin = bin;
        v.exp.diff = d; v.exp.bout = bo; v.exp.zero = z; v.exp.ovf = ov;
        return v;
    endfunction

    function automatic logic [WIDTH-1:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            4:       return 32'h0000_FFFF;
            5:       return 32'h0001_0000;
            default: return $urandom;
        endcase
    endfunction

    function automatic res_t got();
        return {diff, borrow_out, zero, overflow};
    endfunction

    task automatic check_res(input string name, input res_t act, input res_t req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got diff=%h bout=%b zero=%b ovf=%b, expected diff=%h bout=%b zero=%b ovf=%b",
                     name, act.diff, act.bout, act.zero, act.ovf,
                     req.diff, req.bout, req.zero, req.ovf);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %b, expected %b", name, act, req);
        end
    endtask

    task automatic check_int(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic send(input vec_t v);
        bit ok;
        ok        = 0;
        a         = v.a;
        b         = v.b;
        borrow_in = v.bin;
        in_valid  = 1'b1;
        for (int c = 0; c < 200 && !ok; c++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(v.exp);
                accepted++;
                ok = 1;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got in_ready=0 for 200 cycles, expected acceptance");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        for (int c = 0; c < 100 && exp_q.size() != 0; c++) begin
            @(negedge clk);
            #1;
        end
        check_int(name, exp_q.size(), 0);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Output monitor: in-order scoreboard plus hold check while stalled.
    initial begin
        bit   prev_stall;
        res_t prev_res;
        res_t e;
        prev_stall = 0;
        prev_res   = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                prev_stall = 0;
            end else begin
                if (prev_stall) begin
                    check_bit("stall_valid_held", out_valid, 1'b1);
                    check_res("stall_data_held", got(), prev_res);
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_output: got diff=%h with nothing pending, expected no output", diff);
                    end else begin
                        e = exp_q.pop_front();
                        check_res("result", got(), e);
                    end
                end
                prev_stall = out_valid && !out_ready;
                prev_res   = got();
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1);
    end

    initial begin
        int c0;
        int a0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        borrow_in = 1'b0;
        out_ready = 1'b1;

        tbl[0]  = tv(32'h5000_0000, 32'h1000_0000, 1'b0, 32'h4000_0000, 1'b0, 1'b0, 1'b0);
        tbl[1]  = tv(32'h1000_0000, 32'h2000_0000, 1'b0, 32'hF000_0000, 1'b1, 1'b0, 1'b0);
        tbl[2]  = tv(32'h0000_0000, 32'h0000_0000, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
        tbl[3]  = tv(32'h0001_0000, 32'h0000_0001, 1'b0, 32'h0000_FFFF, 1'b0, 1'b0, 1'b0);
        tbl[4]  = tv(32'hAFFF_FFFF, 32'hAFFF_FFFF, 1'b0, 32'h0000_0000, 1'b0, 1'b1, 1'b0);
        tbl[5]  = tv(32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b1);
        tbl[6]  = tv(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
        tbl[7]  = tv(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 1'b1, 1'b0, 1'b1);
        tbl[8]  = tv(32'h0000_0000, 32'h8000_0000, 1'b0, 32'h8000_0000, 1'b1, 1'b0, 1'b1);
        tbl[9]  = tv(32'h0001_0000, 32'h0000_0000, 1'b1, 32'h0000_FFFF, 1'b0, 1'b0, 1'b0);
        tbl[10] = tv(32'h0000_0005, 32'h0000_0003, 1'b1, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
        tbl[11] = tv(32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b1, 1'b0);

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_bit("reset_out_valid", out_valid, 1'b0);
        check_bit("reset_in_ready", in_ready, 1'b1);
        check_res("reset_outputs", got(), '0);

        // Latency: accepted at edge N, visible after edge N+1.
        @(posedge clk);
        #1;
        a = tbl[0].a; b = tbl[0].b; borrow_in = tbl[0].bin; in_valid = 1'b1;
        @(negedge clk);
        check_bit("lat_in_ready", in_ready, 1'b1);
        exp_q.push_back(tbl[0].exp);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        check_bit("lat_not_yet", out_valid, 1'b0);
        @(negedge clk);
        check_bit("lat_valid", out_valid, 1'b1);

        // Whole table back-to-back with out_ready held high.
        @(posedge clk);
        #1;
        c0 = cyc;
        for (int i = 0; i < NV; i++) send(tbl[i]);
        check_int("b2b_cycles", cyc - c0, NV);
        repeat (2) @(negedge clk);
        #1;
        check_int("b2b_drained", exp_q.size(), 0);

        // Stall with continuous input: only two accepts before in_ready drops.
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        a0 = accepted;
        fork
            begin
                for (int i = 0; i < 4; i++) send(tbl[i + 4]);
            end
            begin
                repeat (4) @(negedge clk);
                #1;
                check_int("stall_accepts", accepted - a0, 2);
                check_bit("stall_in_ready", in_ready, 1'b0);
                check_bit("stall_out_valid", out_valid, 1'b1);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        wait_drain("stall_drained");

        // Reset with both stages full: nothing from before reset may emerge.
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        send(tbl[5]);
        send(tbl[6]);
        check_bit("pre_reset_full", out_valid, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        #1;
        check_bit("post_reset_out_valid", out_valid, 1'b0);
        check_bit("post_reset_in_ready", in_ready, 1'b1);
        check_res("post_reset_outputs", got(), '0);
        out_ready = 1'b1;
        repeat (6) @(negedge clk);
        #1;
        check_bit("post_reset_idle", out_valid, 1'b0);

        // Randomized traffic and back-pressure against the model.
        @(posedge clk);
        #1;
        fork
            begin
                vec_t v;
                for (int i = 0; i < 300; i++) begin
                    if ($urandom_range(0, 4) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                    v.a   = pick();
                    v.b   = pick();
                    v.bin = 1'($urandom_range(0, 1));
                    v.exp = model(v.a, v.b, v.bin);
                    send(v);
                end
                rnd_done = 1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        wait_drain("random_drained");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
